mem_bus_initiator: RTL and testbench

- Initiator/requester side of the main-memory port. It takes single-word load/store requests from the CPU datapath over a valid/ready handshake.
- Latches each request into internal MAR/MBR registers and drives the synchronous single-port memory (addr, data_in, write_enable, registered data_out).
- Returns read data and completion status to the datapath over a second valid/ready handshake.
- Sits between the control/datapath and main memory; one transaction in flight at a time.

---
 rtl/mem_bus_initiator_pkg.sv | 17 +
 rtl/mem_bus_initiator_register.sv | 20 ++
 rtl/mem_bus_initiator.sv | 141 ++++++++++++++
 tb/tb_mem_bus_initiator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_initiator_pkg.sv
// Shared types and constants for the memory-bus initiator.
package mem_bus_initiator_pkg;

  localparam int unsigned DEFAULT_ADDR_W    = 16;
  localparam int unsigned DEFAULT_DATA_W    = 16;
  localparam int unsigned DEFAULT_MEM_DEPTH = 16384;

  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mem_bus_initiator_register.sv
// Generic register with load enable and async active-low clear; used as MAR and MBR.
module mem_bus_initiator_register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-outstanding load/store initiator: latches a request into MAR/MBR, runs one
// memory cycle on a synchronous single-port RAM and returns data/status on a response port.
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned MEM_DEPTH    = DEFAULT_MEM_DEPTH,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       err_count
);

  localparam int unsigned        CNT_W       = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0]   CNT_INIT    = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(1);
  localparam logic [ADDR_W:0]    DEPTH_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [15:0]         err_count_q, err_count_d;
  logic                err_inc;
  logic                accept;
  logic                addr_oor;

  // Requests are only looked at in IDLE; anything presented elsewhere is ignored.
  assign accept   = req_valid && (state_q == StIdle);
  assign addr_oor = {1'b0, req_addr} >= DEPTH_LIMIT;

  mem_bus_initiator_register #(.WIDTH(ADDR_W)) u_mar (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept),
    .d       (req_addr),
    .q       (mem_addr)
  );

  mem_bus_initiator_register #(.WIDTH(DATA_W)) u_mbr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept && req_write),
    .d       (req_wdata),
    .q       (mem_wdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_inc     = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_we      = 1'b0;
    err_count_d = (err_count_q == ERR_SAT) ? err_count_q : err_count_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          rdata_d = '0;
          err_d   = addr_oor;
          if (addr_oor) begin
            err_inc = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        mem_we = write_q;
        if (write_q) begin
          state_d = StResp;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (err_inc) begin
        err_count_q <= err_count_d;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: directed and random load/store traffic against a word-array
// reference, plus a READ_LATENCY=3 instance for the capture-timing case.
module tb_mem_bus_initiator;

  localparam int unsigned DEPTH = 16384;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, mem_we;
  logic [15:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata, err_count;

  logic        req_valid3, req_ready3, req_write3, rsp_valid3, rsp_ready3, rsp_err3, mem_we3;
  logic [15:0] req_addr3, req_wdata3, rsp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [15:0] err_count3;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [DEPTH];
  logic [15:0] ref_err;

  mem_bus_initiator #(.READ_LATENCY(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .err_count (err_count)
  );

  mem_bus_initiator #(.READ_LATENCY(3)) dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_write (req_write3),
    .req_addr  (req_addr3),
    .req_wdata (req_wdata3),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready3),
    .rsp_rdata (rsp_rdata3),
    .rsp_err   (rsp_err3),
    .mem_addr  (mem_addr3),
    .mem_wdata (mem_wdata3),
    .mem_we    (mem_we3),
    .mem_rdata (mem_rdata3),
    .err_count (err_count3)
  );

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 40503 + 17);
  endfunction

  // Synchronous single-port memories: read-first, 1-cycle and 3-cycle read pipelines.
  logic [15:0] mem1 [DEPTH];
  logic [15:0] mem3 [DEPTH];
  logic [15:0] rd1_q;
  logic [15:0] p3_0, p3_1, p3_2;
  assign mem_rdata  = rd1_q;
  assign mem_rdata3 = p3_2;

  always @(posedge clk) begin
    rd1_q <= mem1[mem_addr[13:0]];
    if (mem_we) mem1[mem_addr[13:0]] = mem_wdata;
  end

  always @(posedge clk) begin
    p3_0 <= mem3[mem_addr3[13:0]];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
    if (mem_we3) mem3[mem_addr3[13:0]] = mem_wdata3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the READ_LATENCY=1 instance; hold>0 backpressures the response
  // for that many cycles while a stray request is presented.
  task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d, input int hold);
    int          lat;
    int          we_cnt;
    int          exp_lat;
    logic        exp_err;
    logic [15:0] exp_rd;
    exp_err = (a >= 16'(DEPTH));
    exp_lat = exp_err ? 1 : (w ? 2 : 3);
    exp_rd  = (w || exp_err) ? 16'h0000 : ref_mem[a[13:0]];
    if (exp_err) begin
      if (ref_err != 16'hFFFF) ref_err = ref_err + 16'd1;
    end else if (w) begin
      ref_mem[a[13:0]] = d;
    end

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);

    lat = 0;
    we_cnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_we) we_cnt++;
      if (rsp_valid) break;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("we_pulses", 32'(we_cnt), (w && !exp_err) ? 32'd1 : 32'd0);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("err_count", 32'(err_count), 32'(ref_err));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    if (w && !exp_err) chk("mem_wdata", 32'(mem_wdata), 32'(d));
    chk("req_ready_resp", 32'(req_ready), 32'd0);

    if (hold > 0) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'($urandom_range(0, 63));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("bp_ready", 32'(req_ready), 32'd0);
        chk("bp_mar", 32'(mem_addr), 32'(a));
        chk("bp_we", 32'(mem_we), 32'd0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("after_handshake", 32'({rsp_valid, req_ready}), 32'b01);
    rsp_ready = 1'b0;
  endtask

  task automatic txn3(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rd, input int exp_lat);
    int lat;
    @(negedge clk);
    req_valid3 = 1'b1;
    req_write3 = w;
    req_addr3  = a;
    req_wdata3 = d;
    @(posedge clk);
    #1;
    req_valid3 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid3) break;
    end
    chk("rl3_latency", 32'(lat), 32'(exp_lat));
    chk("rl3_rdata", 32'(rsp_rdata3), 32'(exp_rd));
    chk("rl3_err", 32'({rsp_err3, err_count3}), 32'd0);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    chk("rl3_after_handshake", 32'({rsp_valid3, req_ready3}), 32'b01);
    rsp_ready3 = 1'b0;
  endtask

  initial begin
    logic        w;
    logic [15:0] a;
    int          sel;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem1[i]    = init_word(i);
      mem3[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    ref_err = 16'h0000;

    // Reset values
    #12;
    chk("rst_outputs", 32'({mem_we, rsp_valid, rsp_err}), 32'd0);
    chk("rst_regs", {mem_addr, err_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Directed: store/load, range edges, backpressure, rsp_ready already high
    txn(1'b1, 16'h0010, 16'hBEEF, 1);
    txn(1'b0, 16'h0010, 16'h0000, 0);
    txn(1'b0, 16'h4000, 16'h0000, 1);
    txn(1'b0, 16'h3FFF, 16'h0000, 0);
    txn(1'b1, 16'h3FFF, 16'h7777, 0);
    txn(1'b0, 16'h3FFF, 16'h0000, 2);
    txn(1'b0, 16'h1234, 16'h0000, 5);

    // Latency-3 instance: first load sees stale reads in earlier WAIT cycles
    txn3(1'b0, 16'h0100, 16'h0000, init_word(16'h0100), 5);
    txn3(1'b1, 16'h0101, 16'h1357, 16'h0000, 2);
    txn3(1'b0, 16'h0101, 16'h0000, 16'h1357, 5);

    // Reset during ISSUE of a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hCAFE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("issue_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_we_drop", 32'({mem_we, rsp_valid}), 32'd0);
    repeat (3) @(negedge clk);
    chk("no_rsp_in_reset", 32'(rsp_valid), 32'd0);
    reset_n = 1'b1;
    ref_err = 16'h0000;
    @(negedge clk);
    chk("post_rst_ready", 32'({req_ready, rsp_valid, rsp_err, mem_we}), 32'b1000);
    chk("post_rst_regs", {mem_addr, mem_wdata}, 32'd0);
    chk("post_rst_data", {rsp_rdata, err_count}, 32'd0);
    txn(1'b0, 16'h0020, 16'h0000, 0);

    // Saturation of the error counter
    force dut.err_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_count_q;
    ref_err = 16'hFFFE;
    chk("forced_count", 32'(err_count), 32'hFFFE);
    txn(1'b0, 16'h8000, 16'h0000, 0);
    txn(1'b1, 16'h4000, 16'h1111, 1);
    txn(1'b0, 16'hFFFF, 16'h0000, 0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      w   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 16'($urandom_range(DEPTH, 16'hFFFF));
      else if (sel == 1) a = 16'(DEPTH - 1);
      else if (sel == 2) a = 16'(DEPTH);
      else               a = 16'($urandom_range(0, 63));
      txn(w, a, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
